// File: rtl/pfpu_dma_sink_pkg.sv
// Shared constants for the PFPU DMA sink: FIFO entry layout and default depth.
package pfpu_dma_sink_pkg;

  // Entry = {word address[29:0], data[31:0]}
  localparam int unsigned ADR_W              = 30;
  localparam int unsigned DAT_W              = 32;
  localparam int unsigned ENTRY_W            = 62;
  localparam int unsigned ADR_LSB            = 32;
  localparam int unsigned DAT_LSB            = 0;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 3;

  // Pack a word address and data word into one FIFO entry.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADR_W-1:0] adr,
                                                    input logic [DAT_W-1:0] dat);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[ADR_LSB +: ADR_W] = adr;
    e[DAT_LSB +: DAT_W] = dat;
    return e;
  endfunction

endpackage

// File: rtl/pfpu_dma_sink_fifo.sv
// First-word-fall-through register FIFO with occupancy count.
// Head entry is visible on rdata combinationally whenever empty is low.
module pfpu_dma_sink_fifo
  import pfpu_dma_sink_pkg::*;
#(
  parameter int unsigned WIDTH      = ENTRY_W,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rptr_q];
  // Overflow/underflow requests are ignored rather than corrupting state.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage registers, cleared on reset so no stale entry survives a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pfpu_dma_sink.sv
// Write-only Wishbone slave terminating PFPU DMA traffic into a FIFO that drains
// to a strobe/acknowledge stream. Backpressure is applied by withholding ack while full.
// Optional address window check enabled by defining PFPU_DMA_SINK_WINDOW_EN.
module pfpu_dma_sink
  import pfpu_dma_sink_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
  parameter logic [31:0] WIN_MASK   = 32'hFFFF_0000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  output logic                  wbs_ack_o,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic [ADR_W-1:0]      out_adr,
  output logic [DAT_W-1:0]      out_dat,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  err_read,
  output logic                  err_range
);

`ifdef PFPU_DMA_SINK_WINDOW_EN
  localparam logic WIN_EN = 1'b1;
`else
  localparam logic WIN_EN = 1'b0;
`endif

  logic               ack_q, ack_d;
  logic               err_read_q;
  logic               req, wr_req, rd_req;
  logic               in_win, out_of_win, range_drop;
  logic               push;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;

  // Masking with ack_q guarantees at least one idle cycle between acks.
  assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_req     = req & wbs_we_i;
  assign rd_req     = req & ~wbs_we_i;
  assign in_win     = ((wbs_adr_i & WIN_MASK) == WIN_BASE);
  assign out_of_win = WIN_EN & ~in_win;
  // Out-of-window writes are acked regardless of FIFO state so the bus never hangs.
  assign range_drop = wr_req & out_of_win;
  assign push       = wr_req & ~out_of_win & ~fifo_full;
  assign ack_d      = push | range_drop | rd_req;

  // Registered ack and error pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q      <= 1'b0;
      err_read_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      err_read_q <= rd_req;
    end
  end

`ifdef PFPU_DMA_SINK_WINDOW_EN
  logic err_range_q;

  // Range error pulse, coincident with the ack of the dropped write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err_range_q <= 1'b0;
    else            err_range_q <= range_drop;
  end

  assign err_range = err_range_q;
`else
  assign err_range = 1'b0;
`endif

  assign wbs_ack_o = ack_q;
  assign err_read  = err_read_q;
  assign out_stb   = ~fifo_empty;
  assign out_adr   = head[ADR_LSB +: ADR_W];
  assign out_dat   = head[DAT_LSB +: DAT_W];

  pfpu_dma_sink_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .wdata (pack_entry(wbs_adr_i[31:2], wbs_dat_i)),
    .pop   (out_ack),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

endmodule
